aqf_route_sequencer: RTL and testbench
======================================

Name: aqf_route_sequencer

Overview:
- Timed controller for the chip topology: input junction → PumpA → Mixer → PumpC → output junction.
- Generalises that topology to N_IN input ports and N_OUT output ports.
- Accepts route requests (input, output, three phase lengths) over a valid/ready handshake.
- Sequences valve, peristaltic-pump and mixer actuation with cycle-accurate counters.
- Sits between the host command layer and the chip's control-line drivers.

Parameters:
- N_IN, 5, number of input fluid ports (valves on the input junction).
- N_OUT, 3, number of output fluid ports (valves on the output junction).
- CNT_W, 16, width of the per-phase cycle-length fields.
- PUMP_PHASES, 3, number of peristaltic valve phases per pump.
- FLUSH_LEN, 64, flush duration in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  route request present.
- req_ready  out  1  high only in IDLE.
- req_in_sel  in  $clog2(N_IN)  input port index.
- req_out_sel  in  $clog2(N_OUT)  output port index.
- req_load_len  in  CNT_W  LOAD phase cycles.
- req_mix_len  in  CNT_W  MIX phase cycles.
- req_unload_len  in  CNT_W  UNLOAD phase cycles.
- abort  in  1  synchronous abort to IDLE.
- in_valve  out  N_IN  one-hot input valve opens.
- out_valve  out  N_OUT  one-hot output valve opens.
- pump_a  out  PUMP_PHASES  PumpA phase drive.
- pump_c  out  PUMP_PHASES  PumpC phase drive.
- mixer_en  out  1  mixer actuation.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on rejected request.

Behaviour:
- Reset values: all outputs 0 except req_ready=1; state IDLE; counters 0; pump phase registers hold value 1 (phase 0).
- Handshake: a request is accepted on a cycle where req_valid && req_ready. Request fields are registered at acceptance.
- Rejection: if req_in_sel>=N_IN or req_out_sel>=N_OUT, assert err on the next cycle, stay IDLE, drive no actuation.
- States:
  - IDLE: wait for an accepted request.
  - LOAD: in_valve[in_sel]=1, pump_a active.
  - MIX: mixer_en=1, all valves closed, pumps off.
  - UNLOAD: out_valve[out_sel]=1, pump_c active.
  - Normal completion returns to IDLE.
- Phase timing:
  - For a valid request accepted in cycle T, LOAD outputs appear in cycle T+1.
  - Each phase lasts exactly its length in cycles; the down-counter loads len-1 on entry.
  - A zero-length phase is skipped with no dead cycle; the next non-zero phase starts immediately.
  - If all lengths are 0, done pulses at T+1 and state stays IDLE.
  - done pulses in the cycle after the last UNLOAD cycle, coincident with the return to IDLE; req_ready=1 in that same cycle.
- Pumps:
  - While active, the pump output is a one-hot pattern that rotates left by one each cycle, wrapping from PUMP_PHASES-1 to 0.
  - While inactive, the output is 0 and the phase register holds, so the next activation resumes the sequence.
- abort:
  - Sampled every cycle. If high while busy, next cycle is IDLE with all actuation 0; no done, no err.
  - If high in IDLE, the same-cycle request is not accepted and req_ready is forced low.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous); phase registers return to 1.
- Invariant: in_valve and out_valve are never both nonzero.

Optional Feature:
- Macro: AQF_FLUSH_EN.
- Defined:
  - Adds output port flush_valve (1 bit) and state FLUSH after UNLOAD (or after the last non-skipped phase).
  - FLUSH lasts FLUSH_LEN cycles with flush_valve=1, all out_valve bits set, pump_a and pump_c both active, mixer_en=0.
  - done pulses after FLUSH. abort also terminates FLUSH.
- Undefined: no flush_valve port, no FLUSH state, behaviour exactly as above.

Decomposition:
- Package aqf_seq_pkg holds:
  - state enum aqf_seq_state_e (IDLE, LOAD, MIX, UNLOAD, FLUSH), with FLUSH encoded even when unused;
  - request struct aqf_route_req_t;
  - localparam helper for index widths.
- Sub-module aqf_pump_phaser: parameter PUMP_PHASES; ports clk, rst_n, en; output phase. Implements the rotating one-hot with hold. Instantiated twice (PumpA, PumpC).

Test Plan:
- Valid request in=2, out=1, lens 4/3/5 → in_valve=5'b00100 for 4 cycles, mixer_en 3 cycles, out_valve=3'b010 for 5 cycles, done at cycle 13 after acceptance, pump_a sequence 001,010,100,001.
- Request in=5 (N_IN=5) → err pulse next cycle, no actuation, req_ready stays 1.
- Lens 0/2/0 → MIX starts at T+1 for 2 cycles, done at T+3, in_valve/out_valve never asserted.
- abort raised during MIX cycle 2 → all outputs 0 next cycle, busy=0, no done; a following request restarts pump_a from its held phase.
- rst_n low during UNLOAD → outputs 0 asynchronously; after release req_ready=1, pump phase=001.
- With AQF_FLUSH_EN, lens 1/1/1 and FLUSH_LEN=4 → FLUSH for 4 cycles with flush_valve=1 and both pumps rotating, done at T+8.

Source files
------------

// File: rtl/aqf_seq_pkg.sv
// aqf_seq_pkg: shared state encoding, request record and width helper for the
// route sequencer slice.
package aqf_seq_pkg;

    // Storage widths for a registered request; instance parameters must fit.
    localparam int unsigned AQF_SEL_MAX_W = 8;
    localparam int unsigned AQF_LEN_MAX_W = 32;

    // FLUSH keeps its code even in builds without the flush phase.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        MIX    = 3'd2,
        UNLOAD = 3'd3,
        FLUSH  = 3'd4
    } aqf_seq_state_e;

    typedef struct packed {
        logic [AQF_SEL_MAX_W-1:0] inSel;
        logic [AQF_SEL_MAX_W-1:0] outSel;
        logic [AQF_LEN_MAX_W-1:0] loadLen;
        logic [AQF_LEN_MAX_W-1:0] mixLen;
        logic [AQF_LEN_MAX_W-1:0] unloadLen;
    } aqf_route_req_t;

    // Index width for a port count, never narrower than one bit.
    function automatic int unsigned idxWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aqf_pump_phaser.sv
// aqf_pump_phaser: peristaltic pump phase generator. A one-hot pattern rotates
// left once per enabled cycle; while disabled the output is 0 and the pattern
// holds, so the next activation resumes where the last one stopped.
module aqf_pump_phaser #(
    parameter int unsigned PUMP_PHASES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic [PUMP_PHASES-1:0] phase
);

    logic [PUMP_PHASES-1:0] phaseQ;

    // Rotate the held pattern only while the pump is driven.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phaseQ <= PUMP_PHASES'(1);
        end else if (en) begin
            phaseQ <= (phaseQ << 1) | (phaseQ >> (PUMP_PHASES - 1));
        end
    end

    assign phase = en ? phaseQ : '0;

endmodule

// File: rtl/aqf_route_sequencer.sv
// aqf_route_sequencer: timed controller for
// input junction -> PumpA -> Mixer -> PumpC -> output junction.
// Runs LOAD / MIX / UNLOAD for the cycle counts given in each accepted request,
// skipping zero-length phases with no dead cycle.
// Optional macro AQF_FLUSH_EN adds the flush_valve port and a FLUSH phase of
// FLUSH_LEN cycles before completion.
module aqf_route_sequencer
    import aqf_seq_pkg::*;
#(
    parameter int unsigned N_IN        = 5,
    parameter int unsigned N_OUT       = 3,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned PUMP_PHASES = 3,
    parameter int unsigned FLUSH_LEN   = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [idxWidth(N_IN)-1:0]   req_in_sel,
    input  logic [idxWidth(N_OUT)-1:0]  req_out_sel,
    input  logic [CNT_W-1:0]            req_load_len,
    input  logic [CNT_W-1:0]            req_mix_len,
    input  logic [CNT_W-1:0]            req_unload_len,
    input  logic                        abort,
    output logic [N_IN-1:0]             in_valve,
    output logic [N_OUT-1:0]            out_valve,
    output logic [PUMP_PHASES-1:0]      pump_a,
    output logic [PUMP_PHASES-1:0]      pump_c,
    output logic                        mixer_en,
`ifdef AQF_FLUSH_EN
    output logic                        flush_valve,
`endif
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    aqf_seq_state_e state, nextState;
    logic [CNT_W-1:0] cnt, nextCnt;
    aqf_route_req_t reqQ, nextReq;
    logic doneQ, nextDone, errQ, nextErr;
    logic accept, selOk;
    logic [CNT_W-1:0] lenMix, lenUnload;
    logic chkLoad, chkMix, chkUnload, advance;
    logic enA, enC;
    logic unusedBits;

    assign req_ready = (state == IDLE) && !abort;
    assign accept    = req_valid && req_ready;
    assign selOk     = (32'(req_in_sel) < N_IN) && (32'(req_out_sel) < N_OUT);

    // At acceptance the following phases are judged from the live request.
    assign lenMix    = (state == IDLE) ? req_mix_len    : reqQ.mixLen[CNT_W-1:0];
    assign lenUnload = (state == IDLE) ? req_unload_len : reqQ.unloadLen[CNT_W-1:0];

    assign unusedBits = ^{reqQ, FLUSH_LEN};

    // Next-state, counter and pulse logic; chk* mark which phases may follow.
    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        nextReq   = reqQ;
        nextDone  = 1'b0;
        nextErr   = 1'b0;
        chkLoad   = 1'b0;
        chkMix    = 1'b0;
        chkUnload = 1'b0;
        advance   = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (selOk) begin
                        nextReq.inSel     = AQF_SEL_MAX_W'(req_in_sel);
                        nextReq.outSel    = AQF_SEL_MAX_W'(req_out_sel);
                        nextReq.loadLen   = AQF_LEN_MAX_W'(req_load_len);
                        nextReq.mixLen    = AQF_LEN_MAX_W'(req_mix_len);
                        nextReq.unloadLen = AQF_LEN_MAX_W'(req_unload_len);
                        chkLoad           = 1'b1;
                        advance           = 1'b1;
                    end else begin
                        nextErr = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (cnt == '0) begin
                    chkMix  = 1'b1;
                    advance = 1'b1;
                end else begin
                    nextCnt = cnt - CNT_W'(1);
                end
            end
            MIX: begin
                if (cnt == '0) begin
                    chkUnload = 1'b1;
                    advance   = 1'b1;
                end else begin
                    nextCnt = cnt - CNT_W'(1);
                end
            end
            UNLOAD: begin
                if (cnt == '0) begin
                    advance = 1'b1;
                end else begin
                    nextCnt = cnt - CNT_W'(1);
                end
            end
            FLUSH: begin
                if (cnt == '0) begin
                    nextState = IDLE;
                    nextDone  = 1'b1;
                end else begin
                    nextCnt = cnt - CNT_W'(1);
                end
            end
            default: begin
                nextState = IDLE;
                nextCnt   = '0;
            end
        endcase

        // Skip straight to the first remaining phase with a non-zero length.
        if (advance) begin
            if (chkLoad && (req_load_len != '0)) begin
                nextState = LOAD;
                nextCnt   = req_load_len - CNT_W'(1);
            end else if ((chkLoad || chkMix) && (lenMix != '0)) begin
                nextState = MIX;
                nextCnt   = lenMix - CNT_W'(1);
            end else if ((chkLoad || chkMix || chkUnload) && (lenUnload != '0)) begin
                nextState = UNLOAD;
                nextCnt   = lenUnload - CNT_W'(1);
            end else begin
`ifdef AQF_FLUSH_EN
                nextState = FLUSH;
                nextCnt   = CNT_W'(FLUSH_LEN - 1);
`else
                nextState = IDLE;
                nextCnt   = '0;
                nextDone  = 1'b1;
`endif
            end
        end

        if (abort && (state != IDLE)) begin
            nextState = IDLE;
            nextCnt   = '0;
            nextDone  = 1'b0;
            nextErr   = 1'b0;
        end
    end

    // State, counter, request record and status pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            reqQ  <= '0;
            doneQ <= 1'b0;
            errQ  <= 1'b0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            reqQ  <= nextReq;
            doneQ <= nextDone;
            errQ  <= nextErr;
        end
    end

    // Actuation decoded from the current phase only.
    always_comb begin
        in_valve  = '0;
        out_valve = '0;
        mixer_en  = 1'b0;
        enA       = 1'b0;
        enC       = 1'b0;
`ifdef AQF_FLUSH_EN
        flush_valve = 1'b0;
`endif
        unique case (state)
            LOAD: begin
                for (int unsigned i = 0; i < N_IN; i++) begin
                    in_valve[i] = (reqQ.inSel == AQF_SEL_MAX_W'(i));
                end
                enA = 1'b1;
            end
            MIX: begin
                mixer_en = 1'b1;
            end
            UNLOAD: begin
                for (int unsigned i = 0; i < N_OUT; i++) begin
                    out_valve[i] = (reqQ.outSel == AQF_SEL_MAX_W'(i));
                end
                enC = 1'b1;
            end
            FLUSH: begin
`ifdef AQF_FLUSH_EN
                flush_valve = 1'b1;
                out_valve   = '1;
                enA         = 1'b1;
                enC         = 1'b1;
`endif
            end
            default: begin
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = doneQ;
    assign err  = errQ;

    aqf_pump_phaser #(.PUMP_PHASES(PUMP_PHASES)) uPumpA (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (enA),
        .phase (pump_a)
    );

    aqf_pump_phaser #(.PUMP_PHASES(PUMP_PHASES)) uPumpC (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (enC),
        .phase (pump_c)
    );

endmodule

// File: tb/tb_aqf_route_sequencer.sv
// tb_aqf_route_sequencer: directed bench for the route sequencer. A queue of
// expected per-cycle actuation records is built from each request's lengths
// and compared against the DUT every cycle, alongside hand-computed checks.
module tb_aqf_route_sequencer;

    localparam int N_IN  = 5;
    localparam int N_OUT = 3;
    localparam int CNT_W = 16;
    localparam int PP    = 3;
    localparam int FL    = 4;
`ifdef AQF_FLUSH_EN
    localparam int FLX = FL;
`else
    localparam int FLX = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             abort = 1'b0;
    logic [2:0]       req_in_sel = '0;
    logic [1:0]       req_out_sel = '0;
    logic [CNT_W-1:0] req_load_len = '0;
    logic [CNT_W-1:0] req_mix_len = '0;
    logic [CNT_W-1:0] req_unload_len = '0;
    logic             req_ready;
    logic [N_IN-1:0]  in_valve;
    logic [N_OUT-1:0] out_valve;
    logic [PP-1:0]    pump_a;
    logic [PP-1:0]    pump_c;
    logic             mixer_en;
`ifdef AQF_FLUSH_EN
    logic             flush_valve;
`endif
    logic             busy;
    logic             done;
    logic             err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    aqf_route_sequencer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W), .PUMP_PHASES(PP), .FLUSH_LEN(FL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_in_sel(req_in_sel), .req_out_sel(req_out_sel),
        .req_load_len(req_load_len), .req_mix_len(req_mix_len),
        .req_unload_len(req_unload_len), .abort(abort),
        .in_valve(in_valve), .out_valve(out_valve), .pump_a(pump_a), .pump_c(pump_c),
        .mixer_en(mixer_en),
`ifdef AQF_FLUSH_EN
        .flush_valve(flush_valve),
`endif
        .busy(busy), .done(done), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [N_IN-1:0]  inV;
        logic [N_OUT-1:0] outV;
        logic mix, aOn, cOn, fl, done, err, busy;
    } exp_t;

    exp_t q[$];
    int phA = 0;
    int phC = 0;

    task automatic pushRoute(input int inS, input int outS, input int l, input int m, input int u);
        exp_t e;
        e = '0; e.busy = 1'b1; e.inV = N_IN'(1) << inS; e.aOn = 1'b1;
        for (int i = 0; i < l; i++) q.push_back(e);
        e = '0; e.busy = 1'b1; e.mix = 1'b1;
        for (int i = 0; i < m; i++) q.push_back(e);
        e = '0; e.busy = 1'b1; e.outV = N_OUT'(1) << outS; e.cOn = 1'b1;
        for (int i = 0; i < u; i++) q.push_back(e);
`ifdef AQF_FLUSH_EN
        e = '0; e.busy = 1'b1; e.fl = 1'b1; e.outV = '1; e.aOn = 1'b1; e.cOn = 1'b1;
        for (int i = 0; i < FL; i++) q.push_back(e);
`endif
        e = '0; e.done = 1'b1;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t r;
        logic [PP-1:0] ea;
        logic [PP-1:0] ec;
        e = '0;
        if (!rst_n) begin
            q.delete();
            phA = 0;
            phC = 0;
        end else if (q.size() > 0) begin
            e = q.pop_front();
        end
        ea = e.aOn ? (PP'(1) << phA) : '0;
        ec = e.cOn ? (PP'(1) << phC) : '0;
        check("m_in_valve", 32'(in_valve), 32'(e.inV));
        check("m_out_valve", 32'(out_valve), 32'(e.outV));
        check("m_mixer_en", 32'(mixer_en), 32'(e.mix));
        check("m_pump_a", 32'(pump_a), 32'(ea));
        check("m_pump_c", 32'(pump_c), 32'(ec));
        check("m_busy", 32'(busy), 32'(e.busy));
        check("m_done", 32'(done), 32'(e.done));
        check("m_err", 32'(err), 32'(e.err));
        check("m_req_ready", 32'(req_ready), 32'(!e.busy && !abort));
        check("m_valve_excl", 32'((in_valve != '0) && (out_valve != '0)), 32'(0));
`ifdef AQF_FLUSH_EN
        check("m_flush_valve", 32'(flush_valve), 32'(e.fl));
`endif
        if (rst_n) begin
            if (e.aOn) phA = (phA + 1) % PP;
            if (e.cOn) phC = (phC + 1) % PP;
            if (e.busy) begin
                if (abort) q.delete();
            end else if (req_valid && !abort) begin
                if (int'(req_in_sel) >= N_IN || int'(req_out_sel) >= N_OUT) begin
                    r = '0; r.err = 1'b1;
                    q.push_back(r);
                end else begin
                    pushRoute(int'(req_in_sel), int'(req_out_sel), int'(req_load_len),
                              int'(req_mix_len), int'(req_unload_len));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request in the current cycle; returns in the cycle after acceptance.
    task automatic sendReq(input int inS, input int outS, input int l, input int m, input int u);
        req_in_sel     = 3'(inS);
        req_out_sel    = 2'(outS);
        req_load_len   = CNT_W'(l);
        req_mix_len    = CNT_W'(m);
        req_unload_len = CNT_W'(u);
        req_valid      = 1'b1;
        step();
        req_valid      = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        check("done_within_budget", 32'(done), 32'(1));
    endtask

    typedef struct { int i; int o; int l; int m; int u; } vec_t;
    vec_t vecs[5];

    initial begin
        vecs[0] = '{4, 2, 1, 0, 1};
        vecs[1] = '{0, 0, 0, 0, 0};
        vecs[2] = '{3, 1, 3, 0, 0};
        vecs[3] = '{1, 1, 0, 0, 2};
        vecs[4] = '{2, 2, 2, 2, 2};

        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_ready", 32'(req_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_pump_a", 32'(pump_a), 32'(0));

        // Main route 2 -> 1, lengths 4/3/5.
        sendReq(2, 1, 4, 3, 5);
        check("t1_in_valve", 32'(in_valve), 32'(5'b00100));
        check("t1_pa0", 32'(pump_a), 32'(3'b001));
        step(); check("t1_pa1", 32'(pump_a), 32'(3'b010));
        step(); check("t1_pa2", 32'(pump_a), 32'(3'b100));
        step(); check("t1_pa3", 32'(pump_a), 32'(3'b001));
        step();
        check("t1_mix", 32'(mixer_en), 32'(1));
        check("t1_mix_in_closed", 32'(in_valve), 32'(0));
        for (int n = 6; n <= 13 + FLX; n++) begin
            step();
            if (n == 8) check("t1_out_valve", 32'(out_valve), 32'(3'b010));
            if (n == 12 + FLX) check("t1_no_early_done", 32'(done), 32'(0));
            if (n == 13 + FLX) begin
                check("t1_done", 32'(done), 32'(1));
                check("t1_done_ready", 32'(req_ready), 32'(1));
                check("t1_done_idle", 32'(busy), 32'(0));
            end
        end
        step();

        // Out-of-range selects are rejected.
        sendReq(5, 0, 1, 1, 1);
        check("t2_err", 32'(err), 32'(1));
        check("t2_busy", 32'(busy), 32'(0));
        check("t2_ready", 32'(req_ready), 32'(1));
        check("t2_in_valve", 32'(in_valve), 32'(0));
        step();
        check("t2_err_clear", 32'(err), 32'(0));
        sendReq(0, 3, 1, 1, 1);
        check("t2b_err", 32'(err), 32'(1));
        step();

        // Lengths 0/2/0: mix starts immediately.
        sendReq(0, 0, 0, 2, 0);
        check("t3_mix1", 32'(mixer_en), 32'(1));
        step();
        check("t3_mix2", 32'(mixer_en), 32'(1));
        step();
        repeat (FLX) step();
        check("t3_done", 32'(done), 32'(1));
        step();

        // Abort during MIX cycle 2, then abort while idle blocks a request.
        sendReq(4, 0, 1, 3, 2);
`ifndef AQF_FLUSH_EN
        check("t4_pa_resume", 32'(pump_a), 32'(3'b010));
`endif
        step();
        step();
        check("t4_mix2", 32'(mixer_en), 32'(1));
        abort = 1'b1;
        step();
        check("t4_abort_busy", 32'(busy), 32'(0));
        check("t4_abort_mix", 32'(mixer_en), 32'(0));
        check("t4_abort_done", 32'(done), 32'(0));
        req_in_sel = 3'd0; req_out_sel = 2'd0;
        req_load_len = CNT_W'(1); req_mix_len = '0; req_unload_len = '0;
        req_valid = 1'b1;
        #1;
        check("t4_abort_ready", 32'(req_ready), 32'(0));
        step();
        check("t4_not_accepted", 32'(busy), 32'(0));
        abort = 1'b0;
        req_valid = 1'b0;
        sendReq(0, 0, 2, 0, 0);
`ifndef AQF_FLUSH_EN
        check("t4_pa_held", 32'(pump_a), 32'(3'b100));
        step();
        check("t4_pa_wrap", 32'(pump_a), 32'(3'b001));
`endif
        waitDone(40);
        step();

        // Reset asserted during UNLOAD.
        sendReq(0, 2, 1, 1, 3);
        step();
        step();
        check("t5_out_valve", 32'(out_valve), 32'(3'b100));
`ifndef AQF_FLUSH_EN
        check("t5_pc_held", 32'(pump_c), 32'(3'b100));
`endif
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_out", 32'(out_valve), 32'(0));
        check("t5_async_pc", 32'(pump_c), 32'(0));
        check("t5_async_busy", 32'(busy), 32'(0));
        step();
        rst_n = 1'b1;
        step();
        check("t5_ready", 32'(req_ready), 32'(1));
        sendReq(1, 0, 1, 0, 0);
        check("t5_pa_reset", 32'(pump_a), 32'(3'b001));
        check("t5_in_valve", 32'(in_valve), 32'(5'b00010));
        waitDone(40);

        // Back-to-back vectors, each issued in the previous done cycle.
        for (int k = 0; k < 5; k++) begin
            sendReq(vecs[k].i, vecs[k].o, vecs[k].l, vecs[k].m, vecs[k].u);
`ifndef AQF_FLUSH_EN
            if (k == 1) check("t6_zero_done", 32'(done), 32'(1));
`endif
            waitDone(60);
        end
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
